// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch aligner: line width, the NOP
// encoding presented when no instruction is available, the line-buffer FSM
// state type and the wrapping next-line tag helper.
package fetch_pkg;

    localparam int unsigned LINE_W = 64;
    localparam int unsigned TAG_W  = 29;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_VALID = 2'b01,
        S_SPLIT = 2'b10
    } state_e;

    // Tag of the line following 'tag'; wraps from the top of memory to line 0.
    function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] tag);
        return tag + 29'd1;
    endfunction

endpackage

// File: rtl/ifetch_hwsel.sv
// Halfword selector: picks one 16-bit parcel out of a 64-bit fetch line.
module ifetch_hwsel
    import fetch_pkg::*;
(
    input  logic [LINE_W-1:0] line_i,
    input  logic [1:0]        off_i,
    output logic [15:0]       hw_o
);

    // Mux the addressed halfword out of the line.
    always_comb begin
        hw_o = 16'h0000;
        case (off_i)
            2'b00:   hw_o = line_i[15:0];
            2'b01:   hw_o = line_i[31:16];
            2'b10:   hw_o = line_i[47:32];
            2'b11:   hw_o = line_i[63:48];
            default: hw_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/ifetch_align.sv
// Instruction fetch aligner. Presents the instruction at pc from either the
// single held line buffer or the line the SRAM returns this cycle, stitching
// 32-bit instructions that straddle two lines.
// Optional feature macro: IFETCH_RVC_EN (compressed 16-bit instruction support;
// when undefined only halfword-aligned-to-word 32-bit instructions are served).
module ifetch_align
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              cpurst,
    input  logic [31:0]       pc,
    input  logic              isram_cs_ff,
    input  logic [31:3]       isram_adr_ff,
    input  logic [LINE_W-1:0] isram_rdata,
    input  logic              jb_ff,
    output logic [31:0]       rv32_instr,
    output logic              isrv16,
    output logic              instr_valid,
    output logic              fetch_misalign
);

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   lbuf_q, lbuf_d;
    logic [TAG_W-1:0]    ltag_q, ltag_d;
    logic                lvalid_q, lvalid_d;

    logic                lvalid_eff_s;
    logic [TAG_W-1:0]    tag0_s, tag1_s;
    logic                last_hw_s;
    logic                hit0_rd_s, hit0_lb_s, hit1_rd_s, hit1_lb_s;
    logic [LINE_W-1:0]   line0_s, line1_s;
    logic [1:0]          off1_s;
    logic                hw0_present_s, hw1_present_s;
    logic [15:0]         hw0_s, hw1_s;
    logic                is16_s;
    logic                misalign_s;
    logic                split_match_s;
    state_e              base_state_s;
    logic                capture_s;

    // A redirect kills the held line before it can be matched against pc.
    assign lvalid_eff_s = lvalid_q & ~jb_ff;

    assign tag0_s    = pc[31:3];
    assign tag1_s    = next_tag(tag0_s);
    assign last_hw_s = (pc[2:1] == 2'b11);

    // The SRAM line is checked first so it wins when both candidates share a tag.
    assign hit0_rd_s = isram_cs_ff  & (isram_adr_ff == tag0_s);
    assign hit0_lb_s = lvalid_eff_s & (ltag_q == tag0_s);
    assign hit1_rd_s = isram_cs_ff  & (isram_adr_ff == tag1_s);
    assign hit1_lb_s = lvalid_eff_s & (ltag_q == tag1_s);

    assign line0_s = hit0_rd_s ? isram_rdata : lbuf_q;
    assign line1_s = last_hw_s ? (hit1_rd_s ? isram_rdata : lbuf_q) : line0_s;
    assign off1_s  = last_hw_s ? 2'b00 : (pc[2:1] + 2'b01);

    assign hw0_present_s = hit0_rd_s | hit0_lb_s;
    assign hw1_present_s = last_hw_s ? (hit1_rd_s | hit1_lb_s) : hw0_present_s;

    ifetch_hwsel u_hwsel0 (
        .line_i (line0_s),
        .off_i  (pc[2:1]),
        .hw_o   (hw0_s)
    );

    ifetch_hwsel u_hwsel1 (
        .line_i (line1_s),
        .off_i  (off1_s),
        .hw_o   (hw1_s)
    );

`ifdef IFETCH_RVC_EN
    assign is16_s     = (hw0_s[1:0] != 2'b11);
    assign misalign_s = hw0_present_s & ~is16_s & last_hw_s & ~hw1_present_s;
`else
    assign is16_s     = 1'b0;
    assign misalign_s = 1'b0;
`endif

    // Combinational instruction presentation; reset forces the idle NOP view.
    always_comb begin
        rv32_instr     = NOP_INSTR;
        isrv16         = 1'b0;
        instr_valid    = 1'b0;
        fetch_misalign = 1'b0;
        if (cpurst) begin
            rv32_instr     = NOP_INSTR;
            isrv16         = 1'b0;
            instr_valid    = 1'b0;
            fetch_misalign = 1'b0;
        end else if (hw0_present_s & is16_s) begin
            rv32_instr  = {16'h0000, hw0_s};
            isrv16      = 1'b1;
            instr_valid = 1'b1;
        end else if (hw0_present_s & hw1_present_s & ~pc[1]) begin
            rv32_instr  = {hw1_s, hw0_s};
            instr_valid = 1'b1;
        end else if (hw0_present_s & hw1_present_s) begin
            // Halfword-offset 32-bit instruction: only legal with compressed support.
`ifdef IFETCH_RVC_EN
            rv32_instr  = {hw1_s, hw0_s};
            instr_valid = 1'b1;
`else
            rv32_instr  = NOP_INSTR;
            instr_valid = 1'b0;
`endif
        end else begin
            fetch_misalign = misalign_s;
        end
    end

    // In a split, only the line directly after the held lower half may replace it.
    assign split_match_s = isram_cs_ff & (isram_adr_ff == next_tag(ltag_q));
    assign base_state_s  = jb_ff ? S_EMPTY : state_q;
    assign capture_s     = isram_cs_ff & ~((base_state_s == S_SPLIT) & ~split_match_s);

    // Next-state and line-buffer update decisions.
    always_comb begin
        state_d  = base_state_s;
        lbuf_d   = lbuf_q;
        ltag_d   = ltag_q;
        lvalid_d = lvalid_eff_s | capture_s;
        if (capture_s) begin
            lbuf_d = isram_rdata;
            ltag_d = isram_adr_ff;
        end else begin
            lbuf_d = lbuf_q;
            ltag_d = ltag_q;
        end
        case (base_state_s)
            S_EMPTY: begin
                if (isram_cs_ff) begin
                    state_d = misalign_s ? S_SPLIT : S_VALID;
                end else begin
                    state_d = S_EMPTY;
                end
            end
            S_VALID: begin
                state_d = misalign_s ? S_SPLIT : S_VALID;
            end
            S_SPLIT: begin
                state_d = split_match_s ? S_VALID : S_SPLIT;
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
    end

    // FSM and line buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (cpurst) begin
            state_q  <= S_EMPTY;
            lbuf_q   <= 64'h0;
            ltag_q   <= 29'h0;
            lvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lbuf_q   <= lbuf_d;
            ltag_q   <= ltag_d;
            lvalid_q <= lvalid_d;
        end
    end

endmodule

// File: tb/tb_ifetch_align.sv
// Directed bench for ifetch_align. Expectations adapt to IFETCH_RVC_EN.
module tb_ifetch_align;

`ifdef IFETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        cpurst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        isram_cs_ff = 1'b0;
    logic [28:0] isram_adr_ff = 29'h0;
    logic [63:0] isram_rdata = 64'h0;
    logic        jb_ff = 1'b0;
    logic [31:0] rv32_instr;
    logic        isrv16;
    logic        instr_valid;
    logic        fetch_misalign;

    int vectors = 0;
    int miscompares = 0;

    ifetch_align dut (
        .clk            (clk),
        .cpurst         (cpurst),
        .pc             (pc),
        .isram_cs_ff    (isram_cs_ff),
        .isram_adr_ff   (isram_adr_ff),
        .isram_rdata    (isram_rdata),
        .jb_ff          (jb_ff),
        .rv32_instr     (rv32_instr),
        .isrv16         (isrv16),
        .instr_valid    (instr_valid),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rst, input logic jb, input logic cs,
                         input logic [31:0] p, input logic [28:0] a, input logic [63:0] d);
        @(negedge clk);
        cpurst       = rst;
        jb_ff        = jb;
        isram_cs_ff  = cs;
        pc           = p;
        isram_adr_ff = a;
        isram_rdata  = d;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] e_instr,
                         input logic e_rvc, input logic e_valid, input logic e_mis);
        vectors++;
        assert (rv32_instr === e_instr) else begin
            miscompares++;
            $error("FAIL %s rv32_instr observed=%h expected=%h", tag, rv32_instr, e_instr);
        end
        vectors++;
        assert (isrv16 === e_rvc) else begin
            miscompares++;
            $error("FAIL %s isrv16 observed=%b expected=%b", tag, isrv16, e_rvc);
        end
        vectors++;
        assert (instr_valid === e_valid) else begin
            miscompares++;
            $error("FAIL %s instr_valid observed=%b expected=%b", tag, instr_valid, e_valid);
        end
        vectors++;
        assert (fetch_misalign === e_mis) else begin
            miscompares++;
            $error("FAIL %s fetch_misalign observed=%b expected=%b", tag, fetch_misalign, e_mis);
        end
    endtask

    initial begin
        // Reset overrides a hitting SRAM line.
        drive(1'b1, 1'b0, 1'b1, 32'h0, 29'h0, 64'h00A00093_00000013);
        check("rst0", NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 32'h0, 29'h0, 64'h00A00093_00000013);
        check("rst1", NOP, 1'b0, 1'b0, 1'b0);

        // Zero-latency hit on the returned line, then served from the buffer.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 29'h0, 64'h00A00093_00000013);
        check("first_line", 32'h00000013, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h4, 29'h0, 64'h0);
        check("held_pc4", 32'h00A00093, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h8, 29'h0, 64'h0);
        check("tag_miss", NOP, 1'b0, 1'b0, 1'b0);

        // Compressed parcel at a halfword offset.
        drive(1'b0, 1'b0, 1'b1, 32'h12, 29'h2, 64'h1111_2222_4501_0013);
        check("rvc_pc2", RVC ? 32'h00004501 : NOP, RVC, RVC, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h10, 29'h0, 64'h0);
        check("held_pc10", 32'h45010013, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h14, 29'h0, 64'h0);
        check("held_pc14", RVC ? 32'h00002222 : 32'h11112222, RVC, 1'b1, 1'b0);

        // Split instruction across lines 0 and 1, with an unrelated line in between.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 29'h0, 64'h0093_0000_0000_0013);
        check("load_l0", 32'h00000013, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h6, 29'h0, 64'h0);
        check("split_low", NOP, 1'b0, 1'b0, RVC);
        drive(1'b0, 1'b0, 1'b1, 32'h6, 29'h5, 64'hFFFF_FFFF_FFFF_FFFF);
        check("split_other", NOP, 1'b0, 1'b0, RVC);
        drive(1'b0, 1'b0, 1'b1, 32'h6, 29'h1, 64'h0000_0000_0513_00A0);
        check("split_stitch", RVC ? 32'h00A00093 : NOP, 1'b0, RVC, 1'b0);
        drive(1'b0, 1'b0, 0, 32'h8, 29'h0, 64'h0);
        check("after_stitch", RVC ? 32'h000000A0 : 32'h051300A0, RVC, 1'b1, 1'b0);

        // Redirect drops the held line; the same-cycle line is used and kept.
        drive(1'b0, 1'b0, 1'b1, 32'h0, 29'h0, 64'h0093_0000_0000_0013);
        check("reload_l0", 32'h00000013, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h40, 29'h8, 64'hDEAD_BEEF_0123_4567);
        check("jb_new", 32'h01234567, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 29'h0, 64'h0);
        check("jb_old_gone", NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h40, 29'h0, 64'h0);
        check("jb_kept", 32'h01234567, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 29'h0, 64'h0);
        check("jb_inval", NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h40, 29'h0, 64'h0);
        check("jb_empty", NOP, 1'b0, 1'b0, 1'b0);

        // Top-of-memory line stitched with line 0.
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 29'h1FFF_FFFF, 64'h0293_0117_0000_0000);
        check("top_line", 32'h02930117, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 29'h0, 64'h0);
        check("wrap_low", NOP, 1'b0, 1'b0, RVC);
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 29'h0, 64'h0000_0000_0000_0050);
        check("wrap_stitch", RVC ? 32'h00500293 : NOP, 1'b0, RVC, 1'b0);

        // Reset in the middle of a split.
        drive(1'b0, 1'b0, 1'b1, 32'h6, 29'h0, 64'h0093_0000_0000_0013);
        check("split_again", NOP, 1'b0, 1'b0, RVC);
        drive(1'b1, 1'b0, 1'b1, 32'h6, 29'h1, 64'h0000_0000_0513_00A0);
        check("rst_split", NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h6, 29'h0, 64'h0);
        check("post_rst6", NOP, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 29'h0, 64'h0);
        check("post_rst0", NOP, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifetch_align.md
IFETCH_ALIGN -- requirements
Module: ifetch_align

Interface
REQ-001 SHALL have these ports, clock and reset first; one clock, reset synchronous and active-high:
- clk  in  1  core clock
- cpurst  in  1  synchronous active-high reset
- pc  in  32  address of the instruction to present this cycle
- isram_cs_ff  in  1  isram_rdata/isram_adr_ff valid this cycle
- isram_adr_ff  in  29 [31:3]  line address of the returned data
- isram_rdata  in  64  instruction SRAM read line
- jb_ff  in  1  fetch redirected last cycle
- rv32_instr  out  32  aligned instruction
- isrv16  out  1  instruction is 16-bit compressed
- instr_valid  out  1  rv32_instr/isrv16 meaningful
- fetch_misalign  out  1  32-bit instruction split across lines, upper half missing

Function
REQ-002 SHALL hold one line buffer: lbuf[63:0], ltag[31:3], lvalid.
REQ-003 Candidate lines each cycle SHALL be lbuf (if lvalid) and isram_rdata (if isram_cs_ff); isram_rdata wins on tag conflict.
REQ-004 hw0 = halfword pc[2:1] of the candidate line with tag pc[31:3]; hw1 = halfword pc[2:1]+1 of the same line, or halfword 0 of the line with tag pc[31:3]+1 when pc[2:1]==2'b11.
REQ-005 Next-line tag SHALL be computed modulo 2^29: 0x1FFFFFFF+1 = 0.
REQ-006 isrv16 = (hw0[1:0] != 2'b11), qualified by instr_valid.
REQ-007 instr_valid SHALL be 1 iff hw0 present and (isrv16 or hw1 present); purely combinational, zero cycles from isram_rdata.
REQ-008 rv32_instr = {16'b0,hw0} if isrv16, {hw1,hw0} if 32-bit, 32'h00000013 (NOP) if !instr_valid.
REQ-009 fetch_misalign SHALL be 1 iff hw0 present, 32-bit, pc[2:1]==2'b11 and hw1 absent.
REQ-010 FSM states: S_EMPTY (lvalid=0), S_VALID (line held), S_SPLIT (holding lower half of a split instruction).
REQ-011 On isram_cs_ff the buffer SHALL capture isram_rdata/isram_adr_ff at the clock edge, except in S_SPLIT when the returned tag is not ltag+1.
REQ-012 S_EMPTY: isram_cs_ff -> S_SPLIT if fetch_misalign, else S_VALID; no data -> stay.
REQ-013 S_SPLIT: isram_cs_ff with tag ltag+1 -> instruction stitched that cycle (instr_valid=1), capture new line, -> S_VALID; other tag -> stay, lbuf kept.
REQ-014 S_VALID: fetch_misalign -> S_SPLIT; otherwise stay.
REQ-015 jb_ff=1 SHALL invalidate lbuf before candidate selection; same-cycle isram_rdata remains usable and captured; next state from S_EMPTY rules.
REQ-016 pc tag matching no candidate -> instr_valid=0, fetch_misalign=0, state unchanged.

Reset
REQ-017 cpurst SHALL force S_EMPTY, lvalid=0, lbuf=0, ltag=0; while asserted outputs rv32_instr=32'h00000013, isrv16=0, instr_valid=0, fetch_misalign=0, overriding all inputs including mid-split.

Configuration
REQ-018 Macro IFETCH_RVC_EN defined: compressed support as above.
REQ-019 Macro IFETCH_RVC_EN undefined: isrv16 tied 0, S_SPLIT unreachable, fetch_misalign tied 0; pc[1]==1 -> instr_valid=0.

Structure
REQ-020 Shared package fetch_pkg SHALL hold LINE_W=64, NOP constant 32'h00000013, and the FSM state enum.
REQ-021 One sub-module ifetch_hwsel SHALL perform halfword selection (line, offset -> halfword), instantiated for hw0 and hw1.

Verification
REQ-022 Reset, then pc=0, isram_cs_ff=1, adr=0, rdata=64'h00A00093_00000013 -> rv32_instr=32'h00000013, isrv16=0, instr_valid=1.
REQ-023 pc=0x6, line 0 halfword3=0x0093 held, isram_cs_ff=0 -> fetch_misalign=1, S_SPLIT; next cycle line 1 halfword0=0x00A0 -> rv32_instr=32'h00A00093, instr_valid=1.
REQ-024 pc=0x2, halfword1=0x4501 -> isrv16=1, rv32_instr=32'h00004501; with IFETCH_RVC_EN undefined -> instr_valid=0.
REQ-025 S_VALID holding tag 0, jb_ff=1, pc=0x40, isram_cs_ff=1 adr=0x40>>3 -> instruction from new line, old line dropped.
REQ-026 pc=0xFFFFFFFE, 32-bit lower half, next line tag 0 returned -> stitched, instr_valid=1 (wrap).
REQ-027 cpurst asserted in S_SPLIT -> next cycle S_EMPTY, all outputs at reset values.
